// File: rtl/bcd_counter_nd_if.sv
// Counter control/status bundle: count and load controls in, value, carry-out and load error out.
// The master drives the controls; the slave is the counter and drives the status.
interface bcd_counter_nd_if #(
    parameter int DIGITS = 3
);
    logic                  cin;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  cout;
    logic [4*DIGITS-1:0]   q;
    logic                  load_err;

    modport master (
        output cin, up, load, load_val,
        input  cout, q, load_err
    );

    modport slave (
        input  cin, up, load, load_val,
        output cout, q, load_err
    );
endinterface

// File: rtl/bcd_counter_nd.sv
// N-digit up/down BCD counter with checked parallel load and wrap/saturate at terminal count.
// q updates one cycle after a load or step; cout is combinational so instances chain on the same edge.
module bcd_counter_nd #(
    parameter int DIGITS   = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    bcd_counter_nd_if.slave bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0]      q_r;
    logic [W-1:0]      q_inc;
    logic [W-1:0]      q_dec;
    logic [W-1:0]      q_nxt;
    logic              load_err_r;
    logic [DIGITS-1:0] is9;
    logic [DIGITS-1:0] is0;
    logic [DIGITS-1:0] dig_ok;
    logic [DIGITS-1:0] carry;
    logic [DIGITS-1:0] borrow;
    logic              tc_up;
    logic              tc_dn;
    logic              at_tc;
    logic              load_ok;
    logic              step_en;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] d;
        logic [3:0] lv;

        assign d          = q_r[4*i +: 4];
        assign lv         = bus.load_val[4*i +: 4];
        assign is9[i]     = (d == 4'd9);
        assign is0[i]     = (d == 4'd0);
        assign dig_ok[i]  = (lv <= 4'd9);
        assign q_inc[4*i +: 4] = !carry[i]  ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
        assign q_dec[4*i +: 4] = !borrow[i] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
    end

    // carry[i]/borrow[i]: every digit below i is 9 (resp. 0), computed from q_r in one pass
    always_comb begin
        carry     = '0;
        borrow    = '0;
        carry[0]  = 1'b1;
        borrow[0] = 1'b1;
        for (int i = 1; i < DIGITS; i++) begin
            carry[i]  = carry[i-1]  & is9[i-1];
            borrow[i] = borrow[i-1] & is0[i-1];
        end
    end

    assign tc_up   = &is9;
    assign tc_dn   = &is0;
    assign at_tc   = bus.up ? tc_up : tc_dn;
    assign load_ok = &dig_ok;
    assign step_en = bus.cin & ~(SATURATE & at_tc);

    always_comb begin
        q_nxt = q_r;
        if (bus.load) begin
            if (load_ok) begin
                q_nxt = bus.load_val;
            end
        end else if (step_en) begin
            q_nxt = bus.up ? q_inc : q_dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r        <= '0;
            load_err_r <= 1'b0;
        end else begin
            q_r        <= q_nxt;
            load_err_r <= bus.load & ~load_ok;
        end
    end

    assign bus.q        = q_r;
    assign bus.load_err = load_err_r;
    assign bus.cout     = bus.cin & ~bus.load & ~rst & at_tc;
endmodule

// File: tb/tb_bcd_counter_nd.sv
// Scoreboard bench: wrap and saturate 3-digit counters plus a two-stage 2-digit cascade.
module tb_bcd_counter_nd;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_s;
    logic rst_c;

    bcd_counter_nd_if #(.DIGITS(3)) a_if ();
    bcd_counter_nd_if #(.DIGITS(3)) s_if ();
    bcd_counter_nd_if #(.DIGITS(2)) l_if ();
    bcd_counter_nd_if #(.DIGITS(2)) h_if ();

    bcd_counter_nd #(.DIGITS(3), .SATURATE(1'b0)) u_wrap (.clk(clk), .rst(rst_a), .bus(a_if));
    bcd_counter_nd #(.DIGITS(3), .SATURATE(1'b1)) u_sat  (.clk(clk), .rst(rst_s), .bus(s_if));
    bcd_counter_nd #(.DIGITS(2), .SATURATE(1'b0)) u_lo   (.clk(clk), .rst(rst_c), .bus(l_if));
    bcd_counter_nd #(.DIGITS(2), .SATURATE(1'b0)) u_hi   (.clk(clk), .rst(rst_c), .bus(h_if));

    assign h_if.cin = l_if.cout;

    typedef struct {
        int          id;
        logic [15:0] q;
        logic        cout;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;

    int mval[3];
    bit merr[3];
    int mmod[3] = '{1000, 1000, 10000};
    bit msat[3] = '{1'b0, 1'b1, 1'b0};

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int from_bcd(logic [15:0] b);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
        return r;
    endfunction

    function automatic bit bcd_ok(logic [15:0] b);
        for (int i = 0; i < 4; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check(string name, int id, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, id, $time, act, exp);
        end
    endtask

    task automatic apply(int id, bit r, bit ld, bit ci, bit u, logic [15:0] val);
        case (id)
            0: begin rst_a = r; a_if.load = ld; a_if.cin = ci; a_if.up = u; a_if.load_val = val[11:0]; end
            1: begin rst_s = r; s_if.load = ld; s_if.cin = ci; s_if.up = u; s_if.load_val = val[11:0]; end
            default: begin rst_c = r; l_if.cin = ci; l_if.up = u; h_if.up = u; end
        endcase
    endtask

    // Decimal reference model: state after the coming clock edge
    task automatic advance(int id, bit r, bit ld, bit ci, bit u, logic [15:0] val);
        bit tc = u ? (mval[id] == mmod[id] - 1) : (mval[id] == 0);
        if (r) begin
            mval[id] = 0;
            merr[id] = 1'b0;
        end else if (ld) begin
            if (bcd_ok(val)) begin
                mval[id] = from_bcd(val);
                merr[id] = 1'b0;
            end else begin
                merr[id] = 1'b1;
            end
        end else begin
            merr[id] = 1'b0;
            if (ci && !(msat[id] && tc))
                mval[id] = u ? (mval[id] + 1) % mmod[id] : (mval[id] + mmod[id] - 1) % mmod[id];
        end
    endtask

    task automatic step(int id, bit r, bit ld, bit ci, bit u, logic [15:0] val);
        exp_t e;
        bit   lo_tc;
        bit   hi_tc;
        apply(id, r, ld, ci, u, val);
        e.id = id;
        e.q  = to_bcd(mval[id]);
        if (id == 2) begin
            lo_tc  = u ? (mval[2] % 100 == 99) : (mval[2] % 100 == 0);
            hi_tc  = u ? (mval[2] / 100 == 99) : (mval[2] / 100 == 0);
            e.cout = ci & !r & lo_tc;
            e.err  = ci & !r & lo_tc & hi_tc;
        end else begin
            e.cout = ci & !ld & !r & (u ? (mval[id] == mmod[id] - 1) : (mval[id] == 0));
            e.err  = merr[id];
        end
        sb.push_back(e);
        advance(id, r, ld, ci, u, val);
        @(posedge clk);
        #1;
    endtask

    task automatic hv(int id, bit r, bit ld, bit ci, bit u, logic [15:0] val,
                      logic [15:0] eq, logic ec, logic ee);
        exp_t e;
        apply(id, r, ld, ci, u, val);
        e.id = id; e.q = eq; e.cout = ec; e.err = ee;
        sb.push_back(e);
        advance(id, r, ld, ci, u, val);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            me = sb.pop_front();
            case (me.id)
                0: begin
                    check("q",        0, {4'h0, a_if.q},      me.q);
                    check("cout",     0, 16'(a_if.cout),      16'(me.cout));
                    check("load_err", 0, 16'(a_if.load_err),  16'(me.err));
                end
                1: begin
                    check("q",        1, {4'h0, s_if.q},      me.q);
                    check("cout",     1, 16'(s_if.cout),      16'(me.cout));
                    check("load_err", 1, 16'(s_if.load_err),  16'(me.err));
                end
                default: begin
                    check("cascade_q",    2, {h_if.q, l_if.q},  me.q);
                    check("lo_cout",      2, 16'(l_if.cout),    16'(me.cout));
                    check("hi_cout",      2, 16'(h_if.cout),    16'(me.err));
                end
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_s = 1'b1; rst_c = 1'b1;
        apply(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        apply(1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        apply(2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        l_if.load = 1'b0; l_if.load_val = '0;
        h_if.load = 1'b0; h_if.load_val = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state with load and count also asserted; then full up sweep with wrap
        hv(0, 1, 1, 1, 1, 16'h0, 16'h000, 0, 0);
        repeat (1001) step(0, 0, 0, 1, 1, 16'h0);

        // Down wrap and borrow across digits
        hv(0, 1, 0, 0, 0, 16'h0,   16'h001, 0, 0);
        hv(0, 0, 0, 1, 0, 16'h0,   16'h000, 1, 0);
        hv(0, 0, 0, 1, 0, 16'h0,   16'h999, 0, 0);
        hv(0, 0, 0, 1, 0, 16'h0,   16'h998, 0, 0);
        hv(0, 0, 1, 0, 0, 16'h100, 16'h997, 0, 0);
        hv(0, 0, 0, 1, 0, 16'h0,   16'h100, 0, 0);
        hv(0, 0, 0, 0, 0, 16'h0,   16'h099, 0, 0);

        // Load validity
        hv(0, 0, 1, 0, 0, 16'h042, 16'h099, 0, 0);
        hv(0, 0, 1, 0, 0, 16'h3A5, 16'h042, 0, 0);
        hv(0, 0, 0, 0, 0, 16'h0,   16'h042, 0, 1);
        hv(0, 0, 1, 0, 0, 16'h719, 16'h042, 0, 0);
        hv(0, 0, 0, 0, 0, 16'h0,   16'h719, 0, 0);

        // Load beats count, even at terminal count; direction toggling
        hv(0, 0, 1, 0, 1, 16'h999, 16'h719, 0, 0);
        hv(0, 0, 1, 1, 1, 16'h500, 16'h999, 0, 0);
        hv(0, 0, 0, 1, 1, 16'h0,   16'h500, 0, 0);
        hv(0, 0, 0, 1, 0, 16'h0,   16'h501, 0, 0);
        hv(0, 0, 0, 1, 1, 16'h0,   16'h500, 0, 0);
        hv(0, 0, 0, 1, 0, 16'h0,   16'h501, 0, 0);
        hv(0, 0, 0, 0, 1, 16'h0,   16'h500, 0, 0);

        // Reset beats an invalid load and a count; clears the pending error
        hv(0, 0, 1, 0, 1, 16'hFFF, 16'h500, 0, 0);
        hv(0, 1, 1, 1, 1, 16'hABC, 16'h500, 0, 1);
        hv(0, 0, 0, 0, 0, 16'h0,   16'h000, 0, 0);

        // Saturating instance
        hv(1, 1, 0, 0, 0, 16'h0,   16'h000, 0, 0);
        hv(1, 0, 1, 0, 0, 16'h998, 16'h000, 0, 0);
        hv(1, 0, 0, 1, 1, 16'h0,   16'h998, 0, 0);
        hv(1, 0, 0, 1, 1, 16'h0,   16'h999, 1, 0);
        hv(1, 0, 0, 1, 1, 16'h0,   16'h999, 1, 0);
        hv(1, 0, 0, 1, 1, 16'h0,   16'h999, 1, 0);
        hv(1, 0, 1, 0, 0, 16'h001, 16'h999, 0, 0);
        hv(1, 0, 0, 1, 0, 16'h0,   16'h001, 0, 0);
        hv(1, 0, 0, 1, 0, 16'h0,   16'h000, 1, 0);
        hv(1, 0, 0, 1, 0, 16'h0,   16'h000, 1, 0);
        hv(1, 0, 0, 0, 0, 16'h0,   16'h000, 0, 0);

        // Cascade of two 2-digit counters through the combinational carry
        hv(2, 1, 0, 0, 1, 16'h0, 16'h0000, 0, 0);
        repeat (10001) step(2, 0, 0, 1, 1, 16'h0);
        hv(2, 0, 0, 0, 1, 16'h0, 16'h0001, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
